// File: rtl/avalon_arbiter.sv
// Two-master round-robin arbiter for a single register-slave port with a fixed
// one-cycle read latency; a silent slave is answered with ERROR_DATA after TIMEOUT cycles.
module avalon_arbiter #(
    parameter int                    ADDR_WIDTH = 1,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TIMEOUT    = 15,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0Read,
    input  logic                  m0Write,
    input  logic [ADDR_WIDTH-1:0] m0Address,
    input  logic [DATA_WIDTH-1:0] m0DataIn,
    output logic                  m0WaitRequest,
    output logic                  m0ReadValid,
    output logic [DATA_WIDTH-1:0] m0DataOut,

    input  logic                  m1Read,
    input  logic                  m1Write,
    input  logic [ADDR_WIDTH-1:0] m1Address,
    input  logic [DATA_WIDTH-1:0] m1DataIn,
    output logic                  m1WaitRequest,
    output logic                  m1ReadValid,
    output logic [DATA_WIDTH-1:0] m1DataOut,

    output logic                  sRead,
    output logic                  sWrite,
    output logic [ADDR_WIDTH-1:0] sAddress,
    output logic [DATA_WIDTH-1:0] sDataIn,
    input  logic                  sReadValid,
    input  logic [DATA_WIDTH-1:0] sDataOut
);

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_READ
    } state_t;

    state_t     r_state;
    logic       r_grant;
    logic       r_last_grant;
    logic       r_op_write;
    logic [7:0] r_count;

    logic                  w_req0;
    logic                  w_req1;
    logic                  w_pick;
    logic                  w_pick_write;
    logic [ADDR_WIDTH-1:0] w_pick_addr;
    logic [DATA_WIDTH-1:0] w_pick_data;
    logic                  w_rsp_done;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    assign w_req0 = m0Read | m0Write;
    assign w_req1 = m1Read | m1Write;

    // Under contention the master that did not win last time goes first.
    assign w_pick       = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
    assign w_pick_write = w_pick ? m1Write   : m0Write;
    assign w_pick_addr  = w_pick ? m1Address : m0Address;
    assign w_pick_data  = w_pick ? m1DataIn  : m0DataIn;

    assign w_rsp_done = sReadValid || (r_count == TIMEOUT_L);
    assign w_rsp_data = sReadValid ? sDataOut : ERROR_DATA;

    assign m0WaitRequest = !((r_state == ISSUE) && !r_grant);
    assign m1WaitRequest = !((r_state == ISSUE) &&  r_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op_write   <= 1'b0;
            r_count      <= 8'd0;
            sRead        <= 1'b0;
            sWrite       <= 1'b0;
            sAddress     <= '0;
            sDataIn      <= '0;
            m0ReadValid  <= 1'b0;
            m1ReadValid  <= 1'b0;
            m0DataOut    <= '0;
            m1DataOut    <= '0;
        end else begin
            sRead       <= 1'b0;
            sWrite      <= 1'b0;
            m0ReadValid <= 1'b0;
            m1ReadValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_grant    <= w_pick;
                        r_op_write <= w_pick_write;
                        sAddress   <= w_pick_addr;
                        sDataIn    <= w_pick_data;
                        sWrite     <= w_pick_write;
                        sRead      <= !w_pick_write;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_last_grant <= r_grant;
                    r_count      <= 8'd0;
                    r_state      <= r_op_write ? IDLE : WAIT_READ;
                end
                WAIT_READ: begin
                    if (w_rsp_done) begin
                        if (r_grant) begin
                            m1DataOut   <= w_rsp_data;
                            m1ReadValid <= 1'b1;
                        end else begin
                            m0DataOut   <= w_rsp_data;
                            m0ReadValid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Bench for avalon_arbiter: transaction/timestamp reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_avalon_arbiter;

    localparam int          AW  = 1;
    localparam int          DW  = 32;
    localparam int          TO  = 15;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0Read, m0Write, m1Read, m1Write;
    logic [AW-1:0] m0Address, m1Address;
    logic [DW-1:0] m0DataIn, m1DataIn;
    logic          m0WaitRequest, m1WaitRequest;
    logic          m0ReadValid, m1ReadValid;
    logic [DW-1:0] m0DataOut, m1DataOut;
    logic          sRead, sWrite;
    logic [AW-1:0] sAddress;
    logic [DW-1:0] sDataIn;
    logic          sReadValid;
    logic [DW-1:0] sDataOut;

    always #5 clk = ~clk;

    avalon_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .ERROR_DATA(ERR)
    ) dut (
        .clk(clk), .reset(reset),
        .m0Read(m0Read), .m0Write(m0Write), .m0Address(m0Address), .m0DataIn(m0DataIn),
        .m0WaitRequest(m0WaitRequest), .m0ReadValid(m0ReadValid), .m0DataOut(m0DataOut),
        .m1Read(m1Read), .m1Write(m1Write), .m1Address(m1Address), .m1DataIn(m1DataIn),
        .m1WaitRequest(m1WaitRequest), .m1ReadValid(m1ReadValid), .m1DataOut(m1DataOut),
        .sRead(sRead), .sWrite(sWrite), .sAddress(sAddress), .sDataIn(sDataIn),
        .sReadValid(sReadValid), .sDataOut(sDataOut)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: the in-flight transaction described by its timestamps.
    int          busy_until, issue_cyc, rv_cyc;
    logic        cur_m, cur_wr, cur_ans, last_m;
    logic [31:0] rv_data, exp_saddr, exp_sdata;
    logic [31:0] exp_dout [2];
    int          ans_mode;
    logic [31:0] rdata_fix;
    bit          spur_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        busy_until  = 0;
        issue_cyc   = -100;
        rv_cyc      = -100;
        last_m      = 1'b1;
        cur_m       = 1'b0;
        cur_wr      = 1'b1;
        cur_ans     = 1'b0;
        exp_saddr   = 0;
        exp_sdata   = 0;
        exp_dout[0] = 0;
        exp_dout[1] = 0;
    endtask

    task automatic clr_req();
        m0Read = 0; m0Write = 0; m1Read = 0; m1Write = 0;
    endtask

    task automatic set_req(input int m, input int kind);
        logic rd, wr;
        rd = (kind == 1) || (kind == 3);
        wr = (kind == 2) || (kind == 3);
        if (m == 0) begin
            m0Read = rd; m0Write = wr; m0Address = AW'($urandom); m0DataIn = $urandom;
        end else begin
            m1Read = rd; m1Write = wr; m1Address = AW'($urandom); m1DataIn = $urandom;
        end
    endtask

    // One clock: advance the model across the edge, compare every output, drive the slave.
    task automatic step();
        logic r0, r1, in_wait;
        @(posedge clk);
        #1;
        cyc++;
        r0 = m0Read | m0Write;
        r1 = m1Read | m1Write;
        if (!reset && (cyc - 1) >= busy_until && (r0 || r1)) begin
            cur_m     = (r0 && r1) ? !last_m : r1;
            last_m    = cur_m;
            cur_wr    = cur_m ? m1Write : m0Write;
            exp_saddr = cur_m ? 32'(m1Address) : 32'(m0Address);
            exp_sdata = cur_m ? m1DataIn : m0DataIn;
            issue_cyc = cyc;
            if (cur_wr) begin
                busy_until = cyc + 1;
                rv_cyc     = -100;
            end else begin
                cur_ans    = (ans_mode == 2) ? ($urandom % 4 != 0) : (ans_mode == 1);
                rv_data    = cur_ans ? ((rdata_fix != 0) ? rdata_fix : $urandom) : ERR;
                rv_cyc     = cur_ans ? cyc + 2 : cyc + 2 + TO;
                busy_until = rv_cyc;
            end
        end
        if (cyc == rv_cyc) exp_dout[cur_m] = rv_data;

        chk1("m0WaitRequest", m0WaitRequest, !(cyc == issue_cyc && cur_m == 1'b0));
        chk1("m1WaitRequest", m1WaitRequest, !(cyc == issue_cyc && cur_m == 1'b1));
        chk1("m0ReadValid", m0ReadValid, (cyc == rv_cyc && cur_m == 1'b0));
        chk1("m1ReadValid", m1ReadValid, (cyc == rv_cyc && cur_m == 1'b1));
        chk1("sRead", sRead, (cyc == issue_cyc && !cur_wr));
        chk1("sWrite", sWrite, (cyc == issue_cyc && cur_wr));
        chk("sAddress", 32'(sAddress), exp_saddr);
        chk("sDataIn", sDataIn, exp_sdata);
        chk("m0DataOut", m0DataOut, exp_dout[0]);
        chk("m1DataOut", m1DataOut, exp_dout[1]);

        in_wait    = !cur_wr && (cyc > issue_cyc) && (cyc < busy_until);
        sReadValid = 1'b0;
        sDataOut   = $urandom;
        if (issue_cyc == cyc - 1 && !cur_wr && cur_ans) begin
            sReadValid = 1'b1;
            sDataOut   = rv_data;
        end else if (spur_en && !in_wait && ($urandom % 8 == 0)) begin
            sReadValid = 1'b1;
        end
    endtask

    initial begin
        int          pat, ng, n0, n1;
        logic        acc, busy_req;
        reset = 1'b0;
        clr_req();
        m0Address = 0; m1Address = 0; m0DataIn = 0; m1DataIn = 0;
        sReadValid = 0; sDataOut = 0;
        ans_mode = 1; rdata_fix = 0; spur_en = 0;
        model_reset();

        // Power-on reset values
        #2 reset = 1'b1;
        #2;
        chk1("rst m0WaitRequest", m0WaitRequest, 1'b1);
        chk1("rst m1WaitRequest", m1WaitRequest, 1'b1);
        chk1("rst m0ReadValid", m0ReadValid, 1'b0);
        chk1("rst sRead", sRead, 1'b0);
        chk1("rst sWrite", sWrite, 1'b0);
        chk("rst m0DataOut", m0DataOut, 32'h0);
        chk("rst sDataIn", sDataIn, 32'h0);
        step();
        step();
        reset = 1'b0;
        step();

        // Single write from m0
        m0Write = 1; m0Address = 1; m0DataIn = 32'h1234_5678;
        step();
        chk1("wr sWrite", sWrite, 1'b1);
        chk1("wr sRead", sRead, 1'b0);
        chk("wr sAddress", 32'(sAddress), 32'h1);
        chk("wr sDataIn", sDataIn, 32'h1234_5678);
        chk1("wr m0WaitRequest", m0WaitRequest, 1'b0);
        chk1("wr m0ReadValid", m0ReadValid, 1'b0);
        clr_req();
        step();
        chk1("wr idle m0WaitRequest", m0WaitRequest, 1'b1);

        // Single read from m1, slave answers
        m1Read = 1; m1Address = 0; rdata_fix = 32'hCAFE_0001;
        step();
        chk1("rd sRead", sRead, 1'b1);
        chk1("rd m1WaitRequest", m1WaitRequest, 1'b0);
        clr_req();
        step();
        step();
        chk1("rd m1ReadValid", m1ReadValid, 1'b1);
        chk("rd m1DataOut", m1DataOut, 32'hCAFE_0001);
        chk1("rd m0ReadValid", m0ReadValid, 1'b0);
        rdata_fix = 0;
        step();

        // Contention out of reset: both hold writes for four transactions
        #2 reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
        set_req(0, 2);
        set_req(1, 2);
        pat = 0; ng = 0; n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!m0WaitRequest) begin pat = pat << 1;       ng++; n0++; end
            if (!m1WaitRequest) begin pat = (pat << 1) | 1; ng++; n1++; end
            if (i == 6) clr_req();
        end
        chk("cont grant order", 32'(pat), 32'h5);
        chk("cont grant count", 32'(ng), 32'd4);
        chk("cont m0 accepts", 32'(n0), 32'd2);
        chk("cont m1 accepts", 32'(n1), 32'd2);

        // Read timeout with a silent slave; m1 waits behind it
        ans_mode = 0;
        m0Read = 1; m0Address = 0;
        step();
        m0Read = 0;
        for (int i = 2; i <= 18; i++) begin
            step();
            if (i == 5) begin m1Write = 1; m1Address = 1; m1DataIn = 32'h0BAD_F00D; end
            if (i == 17) chk1("to early m0ReadValid", m0ReadValid, 1'b0);
            if (i == 18) begin
                chk1("to m0ReadValid", m0ReadValid, 1'b1);
                chk("to m0DataOut", m0DataOut, 32'hDEAD_BEEF);
            end
        end
        step();
        chk1("to next m1WaitRequest", m1WaitRequest, 1'b0);
        chk1("to next sWrite", sWrite, 1'b1);
        clr_req();
        ans_mode = 1;
        step();

        // Read and write together on m0: write wins
        m0Read = 1; m0Write = 1; m0Address = 1; m0DataIn = 32'h7777_0000;
        step();
        chk1("rw sWrite", sWrite, 1'b1);
        chk1("rw sRead", sRead, 1'b0);
        clr_req();
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("rw m0ReadValid", m0ReadValid, 1'b0);
        end

        // Reset in the middle of a read
        ans_mode = 0;
        m0Read = 1;
        step();
        clr_req();
        step();
        step();
        step();
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk1("abort m0WaitRequest", m0WaitRequest, 1'b1);
        chk1("abort m1WaitRequest", m1WaitRequest, 1'b1);
        chk1("abort m0ReadValid", m0ReadValid, 1'b0);
        chk1("abort m1ReadValid", m1ReadValid, 1'b0);
        chk("abort m0DataOut", m0DataOut, 32'h0);
        chk("abort m1DataOut", m1DataOut, 32'h0);
        chk1("abort sRead", sRead, 1'b0);
        chk1("abort sWrite", sWrite, 1'b0);
        chk("abort sAddress", 32'(sAddress), 32'h0);
        chk("abort sDataIn", sDataIn, 32'h0);
        step();
        reset = 1'b0;
        sReadValid = 1'b1; sDataOut = 32'h5555_AAAA;
        step();
        chk1("late sReadValid m0ReadValid", m0ReadValid, 1'b0);
        set_req(0, 2);
        set_req(1, 2);
        step();
        chk1("post-abort m0WaitRequest", m0WaitRequest, 1'b0);
        chk1("post-abort m1WaitRequest", m1WaitRequest, 1'b1);
        clr_req();
        step();
        step();

        // Randomized traffic with a silent or answering slave and stray sReadValid
        ans_mode = 2;
        spur_en  = 1;
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom % 500 == 0) begin
                #2 reset = 1'b1;
                model_reset();
                clr_req();
                step();
                reset = 1'b0;
            end else begin
                for (int m = 0; m < 2; m++) begin
                    acc      = (issue_cyc == cyc - 1) && (cur_m == m[0]);
                    busy_req = (m == 0) ? (m0Read | m0Write) : (m1Read | m1Write);
                    if (acc || (!busy_req && $urandom % 3 == 0))
                        set_req(m, int'($urandom % 4));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
